// File: rtl/lsu_mem_stage_if.sv
// Bundles the upstream issue, data-memory and writeback signals of the load/store stage.
// The slave modport is the stage itself; master is its environment.
interface lsu_mem_stage_if #(
  parameter int unsigned REG_IDX_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_uop;
  logic [31:0]          in_addr;
  logic [31:0]          in_wdata;
  logic [REG_IDX_W-1:0] in_rd;

  logic                 mem_req;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_ack;
  logic [31:0]          mem_rdata;

  logic                 done;
  logic                 fault;
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [31:0]          wb_data;

  modport slave (
    input  in_valid, in_uop, in_addr, in_wdata, in_rd, mem_ack, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, done, fault, wb_valid, wb_rd, wb_data
  );

  modport master (
    output in_valid, in_uop, in_addr, in_wdata, in_rd, mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, done, fault, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store stage: one single-beat req/ack memory transaction per STR/LDR, with timeout fault.
// Define LSU_ALIGN_CHECK_EN to fault misaligned addresses instead of silently word-aligning them.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned REG_IDX_W      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_stage_if.slave bus
);

  localparam logic [4:0]  UopStr    = 5'b01001;
  localparam logic [4:0]  UopLdr    = 5'b01010;
  localparam int unsigned CntW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e               state_q, state_d;
  logic [31:2]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic                 is_load_q, is_load_d;
  logic                 fault_q, fault_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic                 accept;

  assign accept = bus.in_valid && (bus.in_uop == UopStr || bus.in_uop == UopLdr);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    is_load_d = is_load_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d    = bus.in_addr[31:2];
          wdata_d   = bus.in_wdata;
          rd_d      = bus.in_rd;
          is_load_d = (bus.in_uop == UopLdr);
          fault_d   = 1'b0;
          cnt_d     = '0;
          state_d   = StReq;
`ifdef LSU_ALIGN_CHECK_EN
          if (bus.in_addr[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StReq: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (bus.mem_ack) begin
          if (is_load_q) wb_data_d = bus.mem_rdata;
          fault_d = 1'b0;
          state_d = StDone;
        end else if (TimeoutEn && cnt_q == CntMax) begin
          fault_d = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      is_load_q <= is_load_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
    end
  end

  // All outputs decode registered state only; nothing flows combinationally from in_*.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.mem_req   = (state_q == StReq);
  assign bus.mem_we    = bus.mem_req & ~is_load_q;
  assign bus.mem_addr  = {addr_q, 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign bus.done      = (state_q == StDone);
  assign bus.fault     = bus.done & fault_q;
  assign bus.wb_valid  = bus.done & is_load_q & ~fault_q;
  assign bus.wb_rd     = rd_q;
  assign bus.wb_data   = wb_data_q;

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store stage sitting directly downstream of the ALU in the CPU execute path. It accepts the effective address computed by the ALU for STR (uop 5'b01001) and LDR (uop 5'b01010). It runs one single-beat data-memory transaction over a req/ack handshake. It returns load data to register writeback, with a timeout fault and an optional alignment fault.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: max cycles mem_req may stay high without mem_ack; 0 disables timeout.
- REG_IDX_W, 4: width of destination register index.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream has a uop/address pair this cycle.
- in_ready  output  1  stage can accept; high only in IDLE.
- in_uop  input  5  micro-op from decode; only 5'b01001 (STR) and 5'b01010 (LDR) are acted on.
- in_addr  input  32  effective address (ALU result, lhs+rhs).
- in_wdata  input  32  store data (STR only).
- in_rd  input  REG_IDX_W  destination register (LDR only).
- mem_req  output  1  memory request, held until ack or timeout.
- mem_we  output  1  1 = write (STR), 0 = read (LDR).
- mem_addr  output  32  request address.
- mem_wdata  output  32  write data.
- mem_ack  input  1  memory completion; sampled only while mem_req=1.
- mem_rdata  input  32  read data, valid in the mem_ack cycle.
- done  output  1  one-cycle pulse: transaction finished (success or fault).
- fault  output  1  qualifies done: transaction aborted.
- wb_valid  output  1  one-cycle pulse: write wb_data to wb_rd.
- wb_rd  output  REG_IDX_W  writeback register index.
- wb_data  output  32  loaded word.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid=1 and in_uop is STR or LDR.
  - On accept, latch addr, wdata, rd and is_load (uop==LDR). Clear the timeout counter and go to REQ.
  - in_valid with any other uop is ignored: no state change, no done.
- REG:
  - mem_req=1. mem_addr, mem_we and mem_wdata come from the latched values and stay stable for the whole state.
  - mem_ack=1: capture mem_rdata into wb_data if is_load. Go to DONE with fault=0.
  - Otherwise the counter increments. When the counter equals TIMEOUT_CYCLES-1 without ack (TIMEOUT_CYCLES≠0), go to DONE with fault=1 and drop mem_req.
- DONE:
  - done=1 for exactly one cycle.
  - wb_valid = is_load & ~fault.
  - wb_rd is the latched rd.
  - Next state is IDLE.
- STR never asserts wb_valid.
- A faulted LDR leaves wb_data at its previous value.
- mem_ack outside REG is ignored.
- Outputs are registered-state decodes; there is no combinational path from in_* to mem_*.

## Timing
- Reset values: in_ready=1 (IDLE), mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, fault=0, wb_valid=0, wb_rd=0, wb_data=0.
- Accept in cycle T → mem_req=1 from T+1.
- Ack in cycle T+k (k≥1) → done/wb_valid in T+k+1 → in_ready=1 in T+k+2.
- Minimum accept-to-done latency is 2 cycles. Minimum accept-to-accept spacing is 3 cycles.
- Ack in the first REQ cycle is legal.
- Timeout: mem_req is high for exactly TIMEOUT_CYCLES cycles, then the fault done follows next cycle.
- Ack in the same cycle the counter expires: ack wins, fault=0.
- Reset asserted mid-transaction:
  - mem_req, done and wb_valid go low immediately (asynchronous). The FSM returns to IDLE.
  - No done is ever produced for the aborted transaction.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - On accept, in_addr[1:0]≠2'b00 skips REQ entirely; no mem_req is issued.
  - The FSM goes straight to DONE in T+1 with fault=1, wb_valid=0.
- LSU_ALIGN_CHECK_EN undefined:
  - No alignment check.
  - mem_addr is the latched address with bits [1:0] forced to 2'b00.

## Test plan
- LDR, in_addr=0x100, in_rd=3; ack at the first REQ cycle with mem_rdata=0xDEADBEEF → mem_req for 1 cycle with mem_we=0 and mem_addr=0x100; next cycle done=1, wb_valid=1, wb_rd=3, wb_data=0xDEADBEEF.
- STR, in_addr=0x20, in_wdata=0x12345678; ack after 5 cycles → mem_req high 5 cycles with stable mem_we=1, mem_addr=0x20, mem_wdata=0x12345678; then done=1, wb_valid=0.
- LDR with no ack, TIMEOUT_CYCLES=64 → mem_req high exactly 64 cycles, then done=1, fault=1, wb_valid=0, then in_ready=1.
- in_valid=1 with uop=5'b00001 (ADD) → in_ready stays 1, mem_req stays 0, no done.
- LDR to 0x102:
  - With LSU_ALIGN_CHECK_EN: no mem_req; done=1 and fault=1 at T+1.
  - Without: mem_addr=0x100 and normal completion.
- rst_n pulsed low during REQ → mem_req=0 immediately; after release in_ready=1, and no done or wb_valid pulse occurs.
